// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the PC counter strobes, reads program memory,
// resolves JMP/BZ/HALT locally and hands every other instruction downstream.
module fetch_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int INSTR_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic                   i_zero_flag,
  output logic                   o_pc_reset,
  output logic                   o_pc_load,
  output logic [ADDR_WIDTH-1:0]  o_pc_load_data,
  output logic                   o_pc_increment,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rdata,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr_data,
  input  logic                   i_instr_ready,
  output logic                   o_busy,
  output logic                   o_halted,
  output logic                   o_fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_ISSUE,
    S_HALT
  } seqState_e;

  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BZ   = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  seqState_e              r_state;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [7:0]             r_timeoutCnt;
  logic                   r_instrValid;
  logic                   r_busy;
  logic                   r_halted;
  logic                   r_fetchErr;

  logic [3:0]            w_opcode;
  logic [ADDR_WIDTH-1:0] w_operand;
  logic                  w_active;
  logic                  w_startOk;
  logic                  w_decode;
  logic                  w_take;
  logic                  w_fallThrough;
  logic                  w_accept;

  assign w_opcode  = r_instr[INSTR_WIDTH-1 -: 4];
  assign w_operand = r_instr[ADDR_WIDTH-1:0];

  // Strobes are gated by reset so a reset cycle never disturbs the PC counter.
  assign w_active      = ~i_reset;
  assign w_startOk     = w_active & i_start & ((r_state == S_IDLE) | (r_state == S_HALT));
  assign w_decode      = w_active & (r_state == S_DECODE);
  assign w_take        = w_decode & ((w_opcode == OP_JMP) | ((w_opcode == OP_BZ) & i_zero_flag));
  assign w_fallThrough = w_decode & (w_opcode == OP_BZ) & ~i_zero_flag;
  assign w_accept      = w_active & r_instrValid & i_instr_ready;

  assign o_pc_reset     = w_startOk;
  assign o_pc_load      = w_take;
  assign o_pc_load_data = w_take ? w_operand : '0;
  assign o_pc_increment = w_fallThrough | w_accept;
  assign o_mem_req      = w_active & (r_state == S_FETCH);
  assign o_mem_addr     = o_mem_req ? i_pc : '0;

  assign o_instr_valid = r_instrValid;
  assign o_instr_data  = r_instr;
  assign o_busy        = r_busy;
  assign o_halted      = r_halted;
  assign o_fetch_err   = r_fetchErr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_instr      <= '0;
      r_timeoutCnt <= '0;
      r_instrValid <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_fetchErr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            r_state    <= S_FETCH;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
            r_fetchErr <= 1'b0;
          end
        end
        S_FETCH: begin
          r_timeoutCnt <= '0;
          r_state      <= S_WAIT;
        end
        // The timeout fires on the last WAIT cycle that still lacks read data.
        S_WAIT: begin
          if (i_mem_rvalid) begin
            r_instr <= i_mem_rdata;
            r_state <= S_DECODE;
          end else if (r_timeoutCnt == TIMEOUT_LAST) begin
            r_fetchErr <= 1'b1;
            r_busy     <= 1'b0;
            r_halted   <= 1'b1;
            r_state    <= S_HALT;
          end else begin
            r_timeoutCnt <= r_timeoutCnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (w_opcode == OP_HALT) begin
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if ((w_opcode == OP_JMP) || (w_opcode == OP_BZ)) begin
            r_state <= S_FETCH;
          end else begin
            r_instrValid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_instr_ready) begin
            r_instrValid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random programs, checked by a
// scoreboard fed from an instruction-level reference model of program execution.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  pcReg = '0;
  logic        zeroFlag;
  logic        pcReset;
  logic        pcLoad;
  logic [7:0]  pcLoadData;
  logic        pcIncrement;
  logic        memReq;
  logic [7:0]  memAddr;
  logic        memRvalid;
  logic [15:0] memRdata;
  logic        instrValid;
  logic [15:0] instrData;
  logic        instrReady;
  logic        busy;
  logic        halted;
  logic        fetchErr;

  int nCompared = 0;
  int nMismatched = 0;

  logic [15:0] prog [256];
  logic        zfArr [256];
  logic [7:0]  expAddrQ [$];
  logic [15:0] expIssueQ [$];
  logic [7:0]  refPc;
  logic        refHalted;

  int          pendCount;
  logic [7:0]  pendAddr;
  logic        withhold;
  logic        randReady;
  logic        randLatency;

  logic        prevValid = 1'b0;
  logic        prevReady = 1'b0;
  logic        prevReset = 1'b1;
  logic [15:0] prevData = '0;

  fetch_sequencer #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .i_clk          (clock),
    .i_reset        (reset),
    .i_start        (start),
    .i_pc           (pcReg),
    .i_zero_flag    (zeroFlag),
    .o_pc_reset     (pcReset),
    .o_pc_load      (pcLoad),
    .o_pc_load_data (pcLoadData),
    .o_pc_increment (pcIncrement),
    .o_mem_req      (memReq),
    .o_mem_addr     (memAddr),
    .i_mem_rvalid   (memRvalid),
    .i_mem_rdata    (memRdata),
    .o_instr_valid  (instrValid),
    .o_instr_data   (instrData),
    .i_instr_ready  (instrReady),
    .o_busy         (busy),
    .o_halted       (halted),
    .o_fetch_err    (fetchErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The PC counter the sequencer controls.
  always @(posedge clock) begin
    if (pcReset)          pcReg <= 8'd0;
    else if (pcLoad)      pcReg <= pcLoadData;
    else if (pcIncrement) pcReg <= pcReg + 8'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] actual);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: got 0x%0h with nothing expected at %0t", name, actual, $time);
  endtask

  task automatic refStart();
    refPc = 8'd0;
    refHalted = 1'b0;
    expAddrQ.push_back(8'd0);
  endtask

  // One instruction of the program as the architecture defines it.
  task automatic refStep(input logic zf);
    logic [15:0] ins;
    logic [7:0]  nxt;
    ins = prog[refPc];
    nxt = refPc + 8'd1;
    case (ins[15:12])
      4'h1:    nxt = ins[7:0];
      4'h2:    if (zf) nxt = ins[7:0];
      4'hF:    refHalted = 1'b1;
      default: expIssueQ.push_back(ins);
    endcase
    if (!refHalted) begin
      refPc = nxt;
      expAddrQ.push_back(nxt);
    end
  endtask

  task automatic driveEnv();
    memRvalid = 1'b0;
    if (randReady) instrReady = ($urandom_range(0, 3) != 0);
    if (reset) begin
      pendCount = 0;
      return;
    end
    if (pendCount > 0) begin
      pendCount--;
      if (pendCount == 0) begin
        memRvalid = 1'b1;
        memRdata  = prog[pendAddr];
        zeroFlag  = zfArr[pendAddr];
        refStep(zfArr[pendAddr]);
      end
    end
    if (memReq && !withhold) begin
      pendAddr  = memAddr;
      pendCount = randLatency ? $urandom_range(1, 4) : 1;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    driveEnv();
  endtask

  task automatic applyStimulus(input logic startPulse);
    start = startPulse;
    if (startPulse) begin
      refStart();
      #1;
      checkOutput("pcResetOnStart", pcReset, 1);
    end
    cycle();
    start = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    memRvalid = 1'b0;
    pendCount = 0;
    expAddrQ.delete();
    expIssueQ.delete();
    refHalted = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic checkAllZero();
    checkOutput("rstPcReset", pcReset, 0);
    checkOutput("rstPcLoad", pcLoad, 0);
    checkOutput("rstLoadData", pcLoadData, 0);
    checkOutput("rstPcIncrement", pcIncrement, 0);
    checkOutput("rstMemReq", memReq, 0);
    checkOutput("rstMemAddr", memAddr, 0);
    checkOutput("rstInstrValid", instrValid, 0);
    checkOutput("rstInstrData", instrData, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstHalted", halted, 0);
    checkOutput("rstFetchErr", fetchErr, 0);
  endtask

  function automatic logic [15:0] randInstr();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    op = 4'($urandom_range(3, 14));
    if (r < 15) return {4'h1, 4'h0, 8'($urandom)};
    if (r < 30) return {4'h2, 4'h0, 8'($urandom)};
    if (r < 35) return {4'hF, 12'($urandom)};
    if (r < 42) return {4'h0, 12'($urandom)};
    return {op, 12'($urandom)};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT fetches or hands off an instruction.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (memReq) begin
          if (expAddrQ.size() == 0) reportUnexpected("unexpectedFetch", memAddr);
          else checkOutput("fetchAddr", memAddr, expAddrQ.pop_front());
          checkOutput("memAddrEqPc", memAddr, pcReg);
        end
        if (instrValid && instrReady) begin
          if (expIssueQ.size() == 0) reportUnexpected("unexpectedIssue", instrData);
          else checkOutput("issuedInstr", instrData, expIssueQ.pop_front());
        end
        if (prevValid && !prevReady && !prevReset) begin
          checkOutput("validHeld", instrValid, 1);
          checkOutput("dataHeld", instrData, prevData);
        end
        if (pcReset || pcLoad || pcIncrement)
          checkOutput("strobeOneHot", ($countones({pcReset, pcLoad, pcIncrement}) == 1), 1);
        if (!pcLoad && (pcLoadData != 8'd0)) checkOutput("loadDataZero", pcLoadData, 0);
      end
      prevValid = instrValid;
      prevReady = instrReady;
      prevData  = instrData;
      prevReset = reset;
    end
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; zeroFlag = 1'b0; memRvalid = 1'b0; memRdata = '0;
    instrReady = 1'b0; pendCount = 0; pendAddr = '0; withhold = 1'b0;
    randReady = 1'b0; randLatency = 1'b0; refPc = '0; refHalted = 1'b0;
    foreach (prog[i]) begin
      prog[i] = 16'hF000;
      zfArr[i] = 1'b0;
    end
    prog[8'h00] = 16'h0005;
    prog[8'h01] = 16'h1023;
    prog[8'h23] = 16'h2040;
    prog[8'h40] = 16'h2040;
    prog[8'h41] = 16'hF000;
    zfArr[8'h23] = 1'b1;

    cycle();
    cycle();
    reset = 1'b0;
    #1;
    checkAllZero();

    $display("[TB] issue with stalled consumer");
    applyStimulus(1'b1);
    #1;
    checkOutput("firstMemReq", memReq, 1);
    checkOutput("firstMemAddr", memAddr, 0);
    checkOutput("pcResetOnce", pcReset, 0);
    n = 0;
    while (!instrValid && n < 10) begin cycle(); #1; n++; end
    checkOutput("issueLatency", n, 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stallValid", instrValid, 1);
      checkOutput("stallData", instrData, 16'h0005);
      checkOutput("stallNoInc", pcIncrement, 0);
      cycle();
      #1;
    end
    instrReady = 1'b1;
    #1;
    checkOutput("acceptInc", pcIncrement, 1);
    cycle();
    #1;
    checkOutput("nextFetchAddr", memAddr, 1);

    $display("[TB] jump and branches");
    n = 0;
    while (!pcLoad && n < 10) begin cycle(); #1; n++; end
    checkOutput("jmpLatency", n, 2);
    checkOutput("jmpTarget", pcLoadData, 8'h23);
    checkOutput("jmpNoIssue", instrValid, 0);
    cycle();
    #1;
    checkOutput("jmpFetchAddr", memAddr, 8'h23);
    n = 0;
    while (!pcLoad && n < 10) begin cycle(); #1; n++; end
    checkOutput("bzTakenLatency", n, 2);
    checkOutput("bzTakenTarget", pcLoadData, 8'h40);
    cycle();
    #1;
    n = 0;
    while (!(pcIncrement || pcLoad) && n < 10) begin cycle(); #1; n++; end
    checkOutput("bzNotTakenInc", pcIncrement, 1);
    checkOutput("bzNotTakenNoLoad", pcLoad, 0);
    cycle();
    #1;
    checkOutput("haltFetchAddr", memAddr, 8'h41);
    n = 0;
    while (!halted && n < 10) begin cycle(); #1; n++; end
    checkOutput("haltLatency", n, 3);
    checkOutput("haltBusy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      #1;
      checkOutput("haltNoReq", memReq, 0);
    end

    $display("[TB] fetch timeout");
    withhold = 1'b1;
    applyStimulus(1'b1);
    #1;
    checkOutput("restartAddr", memAddr, 0);
    n = 0;
    while (!halted && n < 40) begin cycle(); #1; n++; end
    refHalted = 1'b1;
    checkOutput("timeoutCycles", n, 17);
    checkOutput("timeoutErr", fetchErr, 1);
    checkOutput("timeoutBusy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      #1;
      checkOutput("errSticky", fetchErr, 1);
    end
    withhold = 1'b0;
    applyStimulus(1'b1);
    #1;
    checkOutput("errCleared", fetchErr, 0);
    checkOutput("restartHalted", halted, 0);
    checkOutput("restartBusy", busy, 1);

    $display("[TB] reset during issue");
    instrReady = 1'b0;
    n = 0;
    while (!instrValid && n < 10) begin cycle(); #1; n++; end
    checkOutput("preResetValid", instrValid, 1);
    reset = 1'b1;
    pendCount = 0;
    expAddrQ.delete();
    expIssueQ.delete();
    cycle();
    reset = 1'b0;
    #1;
    checkAllZero();
    memRvalid = 1'b1;
    memRdata = 16'hBEEF;
    cycle();
    #1;
    checkOutput("staleNoCapture", instrData, 0);
    checkOutput("staleIdle", busy, 0);
    checkOutput("staleNoReq", memReq, 0);

    $display("[TB] random programs");
    randReady = 1'b1;
    randLatency = 1'b1;
    for (int run = 0; run < 10; run++) begin
      foreach (prog[i]) begin
        prog[i] = randInstr();
        zfArr[i] = 1'($urandom);
      end
      applyStimulus(1'b1);
      n = 0;
      while (!halted && n < 600) begin cycle(); n++; end
      n = 0;
      while (!halted && refHalted && n < 6) begin cycle(); n++; end
      #1;
      checkOutput("haltAgreesModel", halted, refHalted);
      if (halted) begin
        checkOutput("randHaltBusy", busy, 0);
        checkOutput("pendingFetches", expAddrQ.size(), 0);
        checkOutput("pendingIssues", expIssueQ.size(), 0);
        for (int k = 0; k < 3; k++) cycle();
      end else begin
        doReset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
